shared_reg_arbiter: RTL and testbench

//  Round-robin write arbiter for a single shared D-type data register.
//  NUM_REQ requesters compete for write access. One winner per arbitration

---
 rtl/shared_reg_arb_pkg.sv | 20 ++
 rtl/shared_reg_arbiter_rr_pick.sv | 29 ++
 rtl/shared_reg_arbiter.sv | 127 ++++++++++++
 tb/tb_shared_reg_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/shared_reg_arb_pkg.sv
// Shared types and helpers for the round-robin shared-register write arbiter.
package shared_reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int CNT_W   = 16;
  localparam int MAX_REQ = 8;

  // One-hot decode of a requester index; callers truncate to their NUM_REQ.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    logic [MAX_REQ-1:0] oh_s;
    oh_s = 8'h01 << idx;
    return oh_s;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req at or above rr_ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

  logic [IDX_W:0] sum_s;
  logic [IDX_W:0] idx_s;

  // Scan offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    valid  = 1'b0;
    winner = {IDX_W{1'b0}};
    sum_s  = {(IDX_W+1){1'b0}};
    idx_s  = {(IDX_W+1){1'b0}};
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      sum_s  = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      idx_s  = (sum_s >= (IDX_W+1)'(NUM_REQ)) ? (sum_s - (IDX_W+1)'(NUM_REQ)) : sum_s;
      valid  = valid | req[idx_s[IDX_W-1:0]];
      winner = req[idx_s[IDX_W-1:0]] ? idx_s[IDX_W-1:0] : winner;
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter for one shared data register with a post-write hold window.
// Define SHARED_REG_ARB_CNT_EN to add the wr_count output counting accepted writes.
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int HOLD_CYC = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [DATA_W-1:0]           q,
  output logic                        busy
`ifdef SHARED_REG_ARB_CNT_EN
  ,
  output logic [CNT_W-1:0]            wr_count
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t              state_r;
  logic [IDX_W-1:0]    rr_ptr_r;
  logic [3:0]          hold_cnt_r;
  logic [NUM_REQ-1:0]  gnt_r;
  logic [DATA_W-1:0]   q_r;
  logic                busy_r;
  logic                pick_valid_s;
  logic [IDX_W-1:0]    pick_winner_s;
  logic [DATA_W-1:0]   lane_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_r),
    .valid  (pick_valid_s),
    .winner (pick_winner_s)
  );

  // Select the winning requester's data lane.
  always_comb begin
    lane_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      lane_s = (pick_winner_s == IDX_W'(i)) ? wdata[i*DATA_W +: DATA_W] : lane_s;
    end
  end

  // Arbitration FSM with pointer, hold counter, data register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      rr_ptr_r   <= {IDX_W{1'b0}};
      hold_cnt_r <= 4'd0;
      gnt_r      <= {NUM_REQ{1'b0}};
      q_r        <= {DATA_W{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            q_r      <= lane_s;
            gnt_r    <= NUM_REQ'(onehot(3'(pick_winner_s)));
            rr_ptr_r <= (pick_winner_s == IDX_W'(NUM_REQ-1)) ? {IDX_W{1'b0}}
                                                             : pick_winner_s + IDX_W'(1);
            busy_r   <= 1'b1;
            state_r  <= GRANT;
          end else begin
            gnt_r  <= {NUM_REQ{1'b0}};
            busy_r <= 1'b0;
          end
        end
        GRANT: begin
          gnt_r <= {NUM_REQ{1'b0}};
          if (HOLD_CYC == 1) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            hold_cnt_r <= 4'(HOLD_CYC - 2);
            busy_r     <= 1'b1;
            state_r    <= HOLD;
          end
        end
        HOLD: begin
          gnt_r <= {NUM_REQ{1'b0}};
          if (hold_cnt_r == 4'd0) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            hold_cnt_r <= hold_cnt_r - 4'd1;
          end
        end
        default: begin
          gnt_r   <= {NUM_REQ{1'b0}};
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign gnt  = gnt_r;
  assign q    = q_r;
  assign busy = busy_r;

`ifdef SHARED_REG_ARB_CNT_EN
  logic [CNT_W-1:0] wr_count_r;

  // Count every entry into GRANT; wraps naturally at the counter width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count_r <= {CNT_W{1'b0}};
    end else if ((state_r == IDLE) && pick_valid_s) begin
      wr_count_r <= wr_count_r + 16'd1;
    end else begin
      wr_count_r <= wr_count_r;
    end
  end

  assign wr_count = wr_count_r;
`endif

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed self-checking bench for shared_reg_arbiter (default parameters).
module tb_shared_reg_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        busy;
`ifdef SHARED_REG_ARB_CNT_EN
  logic [15:0] wr_count;
`endif

  int checks;
  int errors;

  shared_reg_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .wdata    (wdata),
    .gnt      (gnt),
    .q        (q),
    .busy     (busy)
`ifdef SHARED_REG_ARB_CNT_EN
    ,
    .wr_count (wr_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic wait_gnt(output logic [3:0] g);
    g = 4'b0000;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (gnt !== 4'b0000) begin
        g = gnt;
        break;
      end
    end
    if (g === 4'b0000) begin
      checks++;
      errors++;
      $display("FAIL wait_gnt timeout got %b want nonzero", gnt);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (q !== 8'h00)     begin errors++; $display("FAIL reset_q got %h want %h", q, 8'h00); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want %b", gnt, 4'b0000); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b want %b", busy, 1'b0); end
    rst = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL post_reset_gnt got %b want %b", gnt, 4'b0000); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL post_reset_busy got %b want %b", busy, 1'b0); end
  endtask

  task automatic test_single();
    req   = 4'b0100;
    wdata = 32'h11A53344;
    @(negedge clk);
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b want %b", gnt, 4'b0100); end
    checks++; if (q !== 8'hA5)     begin errors++; $display("FAIL single_q got %h want %h", q, 8'hA5); end
    checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL single_busy1 got %b want %b", busy, 1'b1); end
    req = 4'b0000;
    @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_pulse got %b want %b", gnt, 4'b0000); end
    checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL single_busy2 got %b want %b", busy, 1'b1); end
    @(negedge clk);
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL single_busy_fall got %b want %b", busy, 1'b0); end
    checks++; if (q !== 8'hA5)     begin errors++; $display("FAIL single_q_hold got %h want %h", q, 8'hA5); end
  endtask

  task automatic test_fairness();
    logic [3:0] g;
    logic [3:0] exp_g;
    logic [7:0] exp_q;
    do_reset();
    req   = 4'b1111;
    wdata = 32'h44332211;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(g);
      exp_g = 4'b0001 << k;
      exp_q = 8'h11 * 8'(k + 1);
      checks++; if (g !== exp_g) begin errors++; $display("FAIL fair_gnt%0d got %b want %b", k, g, exp_g); end
      checks++; if (q !== exp_q) begin errors++; $display("FAIL fair_q%0d got %h want %h", k, q, exp_q); end
      req[k] = 1'b0;
    end
    req = 4'b1111;
    wait_gnt(g);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL fair_ptr_wrap got %b want %b", g, 4'b0001); end
    req = 4'b0000;
  endtask

  task automatic test_wrap();
    logic [3:0] g;
    req = 4'b0100;
    wait_gnt(g);
    checks++; if (g !== 4'b0100) begin errors++; $display("FAIL wrap_setup got %b want %b", g, 4'b0100); end
    req   = 4'b1001;
    wdata = 32'h3C0000C3;
    wait_gnt(g);
    checks++; if (g !== 4'b1000) begin errors++; $display("FAIL wrap_gnt3 got %b want %b", g, 4'b1000); end
    checks++; if (q !== 8'h3C)   begin errors++; $display("FAIL wrap_q3 got %h want %h", q, 8'h3C); end
    req[3] = 1'b0;
    wait_gnt(g);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL wrap_gnt0 got %b want %b", g, 4'b0001); end
    checks++; if (q !== 8'hC3)   begin errors++; $display("FAIL wrap_q0 got %h want %h", q, 8'hC3); end
    req = 4'b0000;
  endtask

  task automatic test_midop_reset();
    logic [3:0] g;
    req   = 4'b0010;
    wdata = 32'h00005A00;
    wait_gnt(g);
    checks++; if (g !== 4'b0010) begin errors++; $display("FAIL mid_gnt got %b want %b", g, 4'b0010); end
    req = 4'b0000;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_hold_busy got %b want %b", busy, 1'b1); end
    rst = 1'b1;
    #1;
    checks++; if (q !== 8'h00)     begin errors++; $display("FAIL mid_q got %h want %h", q, 8'h00); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL mid_busy got %b want %b", busy, 1'b0); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mid_gnt_clr got %b want %b", gnt, 4'b0000); end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mid_no_gnt%0d got %b want %b", n, gnt, 4'b0000); end
    end
    req   = 4'b0011;
    wdata = 32'h0000E2E1;
    wait_gnt(g);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL mid_ptr_clr got %b want %b", g, 4'b0001); end
    checks++; if (q !== 8'hE1)   begin errors++; $display("FAIL mid_q0 got %h want %h", q, 8'hE1); end
    req[0] = 1'b0;
    wait_gnt(g);
    checks++; if (g !== 4'b0010) begin errors++; $display("FAIL mid_gnt1 got %b want %b", g, 4'b0010); end
    checks++; if (q !== 8'hE2)   begin errors++; $display("FAIL mid_q1 got %h want %h", q, 8'hE2); end
    req = 4'b0000;
  endtask

  task automatic test_idle_hold();
    wdata = 32'hFFFFFFFF;
    repeat (5) @(negedge clk);
    checks++; if (q !== 8'hE2)     begin errors++; $display("FAIL idle_q got %h want %h", q, 8'hE2); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL idle_busy got %b want %b", busy, 1'b0); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL idle_gnt got %b want %b", gnt, 4'b0000); end
  endtask

`ifdef SHARED_REG_ARB_CNT_EN
  task automatic test_count();
    logic [3:0] g;
    do_reset();
    checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL cnt_reset got %h want %h", wr_count, 16'd0); end
    for (int n = 0; n < 5; n++) begin
      req   = 4'b0001;
      wdata = 32'(n);
      wait_gnt(g);
      req = 4'b0000;
    end
    repeat (3) @(negedge clk);
    checks++; if (wr_count !== 16'd5) begin errors++; $display("FAIL cnt_five got %h want %h", wr_count, 16'd5); end
    force dut.wr_count_r = 16'hFFFF;
    #1;
    release dut.wr_count_r;
    req = 4'b0001;
    wait_gnt(g);
    req = 4'b0000;
    checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL cnt_wrap got %h want %h", wr_count, 16'd0); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    clk    = 1'b0;
    rst    = 1'b1;
    req    = 4'b1111;
    wdata  = 32'h44332211;
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_midop_reset();
    test_idle_hold();
`ifdef SHARED_REG_ARB_CNT_EN
    test_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
